// File: rtl/kgp_alu_pkg.sv
// kgp_alu_pkg: shared widths, FSM states and helpers for the KGP-RISC iterative ALU units
package kgp_alu_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} mult_state_t;
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction
endpackage

// File: rtl/seq_mult_if.sv
// seq_mult_if: start/done operand and result bundle for the sequential multiplier
interface seq_mult_if import kgp_alu_pkg::*; ();
    logic               start;
    logic               is_signed;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] P;
    modport master (output start, is_signed, A, B, input busy, done, P);
    modport slave  (input start, is_signed, A, B, output busy, done, P);
endinterface

// File: rtl/seq_mult_pp_gen.sv
// pp_gen: masked partial product, multiplicand gated by one multiplier bit
module pp_gen import kgp_alu_pkg::*; (
    input  logic [WIDTH-1:0] mcand,
    input  logic             bit_i,
    output logic [WIDTH-1:0] pp
);
    assign pp = mcand & {WIDTH{bit_i}};
endmodule

// File: rtl/seq_mult.sv
// seq_mult: 32x32->64 shift-and-add multiplier, magnitudes multiplied then sign-corrected
module seq_mult import kgp_alu_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    seq_mult_if.slave  bus
);
    mult_state_t        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_lo_q, acc_lo_d, pp;
    logic [WIDTH:0]     acc_hi_q, acc_hi_d, sum;
    logic               neg_q, neg_d, busy_q, busy_d, done_q, done_d;
    logic [2*WIDTH-1:0] p_q, p_d, prod;

    pp_gen u_pp (.mcand(mcand_q), .bit_i(mplier_q[0]), .pp(pp));

    assign sum  = acc_hi_q + {1'b0, pp};
    assign prod = {acc_hi_q[WIDTH-1:0], acc_lo_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        p_d      = p_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = bus.start ? RUN : IDLE;
                busy_d  = bus.start;
                if (bus.start) begin
                    neg_d    = bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    mcand_d  = mag(bus.A, bus.is_signed);
                    mplier_d = mag(bus.B, bus.is_signed);
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = {sum, acc_lo_q} >> 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = (cnt_q == CNT_W'(WIDTH-1)) ? FIX : RUN;
            end
            FIX: begin
                p_d     = neg_q ? -prod : prod;
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            p_q      <= p_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.P    = p_q;
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: randomized and directed checks of seq_mult against an arithmetic product model
module tb_seq_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [63:0] last_p = '0;

    seq_mult_if bus ();
    seq_mult dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'({32'b0, a});
        y = s ? longint'($signed(b)) : longint'({32'b0, b});
        return 64'(x * y);
    endfunction

    // Call at a negedge; returns just after the acceptance edge with operands scrambled.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.A = a;
        bus.B = b;
        bus.is_signed = s;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.is_signed = 1'($urandom_range(0, 1));
    endtask

    // lat counts the rising edge that follows each sample; ends at the sample where done is seen.
    task automatic wait_done(input int pulse_at, input logic [63:0] hold,
                             output int lat, output int busy_bad, output int p_bad);
        lat = 0;
        busy_bad = 0;
        p_bad = 0;
        while (lat < 100) begin
            lat++;
            @(negedge clk);
            bus.start = (lat == pulse_at);
            if (lat == pulse_at) begin
                bus.A = 32'd9;
                bus.B = 32'd9;
                bus.is_signed = 1'b0;
            end
            if (bus.done) break;
            if (!bus.busy) busy_bad++;
            if (bus.P !== hold) p_bad++;
        end
        bus.start = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int pulse_at,
                         output int lat, output int busy_bad, output int p_bad);
        @(negedge clk);
        start_op(a, b, s);
        wait_done(pulse_at, last_p, lat, busy_bad, p_bad);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests++; if (bus.P !== 64'd0) begin fails++; $display("FAIL reset_p: got %h expected 0", bus.P); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat, bb, pb;
        do_op(32'd3, 32'd5, 1'b0, 0, lat, bb, pb);
        tests++; if (lat != 34) begin fails++; $display("FAIL basic_latency: got %0d expected 34", lat); end
        tests++; if (bus.P !== 64'hF) begin fails++; $display("FAIL basic_p: got %h expected %h", bus.P, 64'hF); end
        tests++; if (bb != 0) begin fails++; $display("FAIL basic_busy: busy low %0d cycles expected 0", bb); end
        tests++; if (pb != 0) begin fails++; $display("FAIL basic_p_held: P changed %0d cycles expected 0", pb); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL basic_busy_at_done: got %b expected 0", bus.busy); end
        last_p = 64'hF;
        @(negedge clk);
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
        tests++; if (bus.P !== 64'hF) begin fails++; $display("FAIL basic_p_after: got %h expected %h", bus.P, 64'hF); end
    endtask

    task automatic test_vectors;
        logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000, 32'h0};
        logic [31:0] vb [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h3, 32'h1, 32'h1234_5678};
        logic        vs [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        int lat, bb, pb;
        logic [31:0] a, b;
        logic s;
        logic [63:0] exp_p;
        for (int i = 0; i < 18; i++) begin
            a = (i < 6) ? va[i] : $urandom;
            b = (i < 6) ? vb[i] : $urandom;
            s = (i < 6) ? vs[i] : 1'($urandom_range(0, 1));
            exp_p = model_mul(a, b, s);
            do_op(a, b, s, 0, lat, bb, pb);
            tests++;
            if (bus.P !== exp_p || lat != 34 || bb != 0 || pb != 0) begin
                fails++;
                $display("FAIL vec%0d %h*%h s=%b: got P=%h lat=%0d busy_low=%0d p_chg=%0d expected P=%h lat=34", i, a, b, s, bus.P, lat, bb, pb, exp_p);
            end
            last_p = exp_p;
        end
    endtask

    task automatic test_ignored_start;
        int lat, bb, pb, extra;
        do_op(32'd3, 32'd5, 1'b0, 10, lat, bb, pb);
        tests++; if (bus.P !== 64'd15) begin fails++; $display("FAIL ignore_p: got %h expected %h", bus.P, 64'd15); end
        tests++; if (lat != 34) begin fails++; $display("FAIL ignore_latency: got %0d expected 34", lat); end
        last_p = 64'd15;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        tests++; if (extra != 0) begin fails++; $display("FAIL ignore_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        int lat, bb, pb;
        do_op(32'd3, 32'd5, 1'b0, 0, lat, bb, pb);
        tests++; if (bus.P !== 64'd15) begin fails++; $display("FAIL b2b_first_p: got %h expected %h", bus.P, 64'd15); end
        last_p = 64'd15;
        start_op(32'd2, 32'd4, 1'b0);
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy got %b expected 1", bus.busy); end
        wait_done(0, last_p, lat, bb, pb);
        tests++; if (lat != 34) begin fails++; $display("FAIL b2b_latency: got %0d expected 34", lat); end
        tests++; if (bus.P !== 64'd8) begin fails++; $display("FAIL b2b_second_p: got %h expected %h", bus.P, 64'd8); end
        tests++; if (pb != 0) begin fails++; $display("FAIL b2b_hold: P changed %0d cycles expected 0", pb); end
        last_p = 64'd8;
    endtask

    task automatic test_reset_mid;
        int lat, bb, pb, stray;
        @(negedge clk);
        start_op(32'd3, 32'd5, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        tests++; if (bus.P !== 64'd0) begin fails++; $display("FAIL midrst_p: got %h expected 0", bus.P); end
        @(negedge clk);
        rst_n = 1'b1;
        last_p = '0;
        stray = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.done) stray++;
        end
        tests++; if (stray != 0) begin fails++; $display("FAIL midrst_stray_done: got %0d expected 0", stray); end
        do_op(32'd6, 32'd7, 1'b0, 0, lat, bb, pb);
        tests++; if (bus.P !== 64'd42 || lat != 34) begin fails++; $display("FAIL midrst_next: got P=%h lat=%0d expected P=%h lat=34", bus.P, lat, 64'd42); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.A = '0;
        bus.B = '0;
        test_reset;
        test_basic;
        test_vectors;
        test_ignored_start;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_mult.md
# seq_mult

Iterative 32×32→64 shift-and-add multiplier for the KGP-RISC execute stage. Each cycle it forms one AND-masked partial product, multiplicand & {32{multiplier bit}}, and accumulates it. It sits beside the combinational logic unit and serves the MUL-class opcodes (signed and unsigned). Operands are accepted with a start/done handshake, and the fixed latency is 34 cycles.

## Interface
- `WIDTH`, 32, operand width; product is 2×WIDTH.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `is_signed`  in  1  1 = two's-complement operands; 0 = unsigned.
- `A`  in  WIDTH  multiplicand; sampled with `start`.
- `B`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high from the cycle after acceptance until `done`.
- `done`  out  1  one-cycle pulse; `P` is valid.
- `P`  out  2×WIDTH  product; held until the next acceptance.

## Operation
- States:
  - IDLE: wait for `start`.
  - RUN: 32 iterations.
  - FIX: sign correction.
  - DONE: 1 cycle.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→FIX when the iteration counter reaches WIDTH-1.
  - FIX→DONE unconditionally.
  - DONE→RUN if `start`=1 (back-to-back acceptance). Otherwise DONE→IDLE.
- On acceptance:
  - latch `neg` = `is_signed` & (A[31]^B[31]).
  - latch magnitudes |A| and |B|, or the raw values when unsigned.
  - clear the 64-bit accumulator and the 5-bit counter.
- RUN, per cycle:
  - acc_hi is 33 bits; acc_hi ← acc_hi + (mcand & {32{mplier[0]}}).
  - {acc_hi, acc_lo} shifts right by 1.
  - mplier shifts right by 1.
  - counter increments.
- Magnitude of 0x80000000 is 0x80000000 unsigned. The magnitude path is 32-bit unsigned, so no overflow occurs.
- FIX: P ← `neg` ? −acc : acc (64-bit two's complement). The result never truncates.
- `start` while `busy`=1 is ignored, with no side effects. A/B/`is_signed` changes during RUN have no effect.
- Reset, including mid-operation:
  - state IDLE.
  - `busy`=0, `done`=0, `P`=0.
  - counter and accumulator cleared.
  - an in-flight operation is discarded with no `done`.

## Timing
- `start` sampled at edge k, state IDLE → RUN from k. `busy`=1 after k.
- RUN occupies edges k+1 … k+32.
- FIX occurs at edge k+33.
- `done`=1 and `P` is updated in the cycle after k+33. `done` drops after edge k+34.
- Latency: 34 cycles from the acceptance edge to `done`. It is independent of operand values (no early termination).
- `busy` falls in the same cycle `done` rises, so `start` may be re-asserted while `done`=1 and is accepted at edge k+34.
- Throughput: one result per 34 cycles.
- Outputs are registered. No combinational path from inputs to outputs.
- Reset values: `busy`=0, `done`=0, `P`=0.

## Structure
- Shared package `kgp_alu_pkg`:
  - `WIDTH`.
  - `CNT_W` = clog2(WIDTH).
  - state enum `mult_state_t` {IDLE, RUN, FIX, DONE}.
- The package is reused by future divider and shifter FSMs.
- One natural sub-module: `pp_gen`, a purely combinational WIDTH-bit masked partial-product generator (mcand & {WIDTH{bit}}).
- The FSM, counter and accumulator live in `seq_mult`.

## Test plan
- Unsigned A=3, B=5 → `done` exactly 34 cycles after acceptance, P=0x0000_0000_0000_000F, `busy` high for 34 cycles.
- Unsigned A=B=0xFFFF_FFFF → P=0xFFFF_FFFE_0000_0001. Signed -1×-1 → P=0x0000_0000_0000_0001.
- Signed A=0x8000_0000, B=0x8000_0000 → P=0x4000_0000_0000_0000. Signed -7×3 → P=0xFFFF_FFFF_FFFF_FFEB.
- `start` pulsed with A=9, B=9 at cycle 10 of a 3×5 run → ignored, P=15, exactly one `done`.
- `start` held during `done` with A=2, B=4 → accepted immediately, second `done` 34 cycles later with P=8. First P=15 is held until then.
- `rst_n` low at RUN cycle 20 → `busy`=0, `done`=0, `P`=0 immediately. No `done` afterwards. Next 6×7 → P=42.
